// File: rtl/booth_iter_multiplier.sv
// Iterative radix-2^DIGIT signed/unsigned multiplier: magnitudes are accumulated DIGIT bits per cycle, sign applied in FIX.
// Optional build macro BOOTH_MULT_EARLY_EXIT_EN: leave CALC as soon as the remaining multiplier bits are zero.
module booth_iter_multiplier #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 En,
  input  logic                 Start,
  input  logic                 Sign,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Product
);

  localparam int PW   = 2 * WIDTH;
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);
  localparam int DL   = $clog2(DIGIT);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  mag_a_q, mag_a_d;
  logic [WIDTH-1:0]  mag_b_q, mag_b_d;
  logic              neg_q, neg_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [PW-1:0]     product_q, product_d;

  logic [PW-1:0]     digit_mult;
  logic [PW-1:0]     digit_shifted;
  logic [CW+1:0]     shamt;
  logic [WIDTH-1:0]  mag_b_next;
  logic              last_digit;

  // Digit multiple built from shifted copies of magA selected by the low multiplier bits.
  always_comb begin
    digit_mult = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (mag_b_q[i]) digit_mult = digit_mult + (PW'(mag_a_q) << i);
    end
    shamt         = {2'b00, cnt_q} << DL;
    digit_shifted = digit_mult << shamt;
    mag_b_next    = mag_b_q >> DIGIT;
`ifdef BOOTH_MULT_EARLY_EXIT_EN
    last_digit    = (mag_b_next == '0) || (cnt_q == CW'(NDIG - 1));
`else
    last_digit    = (cnt_q == CW'(NDIG - 1));
`endif
  end

  // NOTE: every signal assigned here gets a default first, so no path can leave a latch behind.
  always_comb begin
    state_d   = state_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          mag_a_d = (Sign && A[WIDTH-1]) ? -A : A;
          mag_b_d = (Sign && B[WIDTH-1]) ? -B : B;
          neg_d   = Sign & (A[WIDTH-1] ^ B[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d   = acc_q + digit_shifted;
        mag_b_d = mag_b_next;
        cnt_d   = cnt_q + CW'(1);
        if (last_digit) state_d = S_FIX;
      end
      S_FIX: begin
        product_d = neg_q ? -acc_q : acc_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else if (En) begin
      state_q   <= state_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Product = product_q;

endmodule

// File: tb/tb_booth_iter_multiplier.sv
// Scoreboard bench for booth_iter_multiplier: driver pushes expected product and Done edge, monitor pops on each Done pulse.
module tb_booth_iter_multiplier;
  localparam int W    = 32;
  localparam int D    = 4;
  localparam int NDIG = W / D;
`ifdef BOOTH_MULT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [2*W-1:0] prod;
    int             done_at;
  } exp_t;

  logic           Clk = 1'b0;
  logic           Reset, En, Start, Sign;
  logic [W-1:0]   A, B;
  logic           Busy, Done;
  logic [2*W-1:0] Product;

  int             total = 0;
  int             bad   = 0;
  int             cyc   = 0;
  exp_t           q[$];
  logic [2*W-1:0] last_prod = '0;
  logic           prev_done = 1'b0;
  logic           en_e, rst_e;
  exp_t           got;
  logic [W-1:0]   ext [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

  booth_iter_multiplier #(.WIDTH(W), .DIGIT(D)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Start(Start), .Sign(Sign),
    .A(A), .B(B), .Busy(Busy), .Done(Done), .Product(Product)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @edge %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // Reference: plain 64-bit integer product.
  function automatic logic [2*W-1:0] model(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Edges from Start acceptance to Done, inclusive.
  function automatic int latency(input logic sg, input logic [W-1:0] b);
    logic [W-1:0] m;
    int n;
    m = (sg && b[W-1]) ? -b : b;
    n = 1;
    m = m >> D;
    while (m != 0) begin
      n++;
      m = m >> D;
    end
    return EARLY ? n + 2 : NDIG + 2;
  endfunction

  always @(posedge Clk) cyc++;

  // Monitor
  always @(posedge Clk) begin
    en_e  = En;
    rst_e = Reset;
    #1;
    if (rst_e) begin
      check("rst_busy", Busy, 0);
      check("rst_done", Done, 0);
      check("rst_prod", Product, 0);
      last_prod = '0;
    end else if (prev_done) begin
      if (en_e) check("done_clear", Done, 0);
      else      check("done_hold", Done, 1);
      check("prod_hold", Product, last_prod);
    end else if (Done) begin
      if (q.size() == 0) begin
        check("spurious_done", Done, 0);
      end else begin
        got = q.pop_front();
        check("product", Product, got.prod);
        check("done_edge", cyc, got.done_at);
        check("busy_at_done", Busy, 0);
        last_prod = got.prod;
      end
    end else begin
      check("prod_hold", Product, last_prod);
    end
    prev_done = rst_e ? 1'b0 : Done;
  end

  // Starts at a negedge with the DUT idle, returns at the negedge after Done.
  task automatic run_op(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall_at, input int stall_len, input bit poke);
    exp_t e;
    int rel;
    e.prod    = model(sg, a, b);
    e.done_at = cyc + latency(sg, b) + stall_len;
    Sign = sg; A = a; B = b; Start = 1'b1; En = 1'b1;
    q.push_back(e);
    @(negedge Clk);
    rel = 1;
    Start = 1'b0;
    A = $urandom; B = $urandom; Sign = 1'($urandom);
    while (q.size() != 0 && rel < 60) begin
      check("busy", Busy, 1);
      Start = poke && (rel == 3);
      En    = !(stall_len > 0 && rel >= stall_at && rel < stall_at + stall_len);
      @(negedge Clk);
      rel++;
    end
    check("drain", q.size(), 0);
    q.delete();
    Start = 1'b0;
    En    = 1'b1;
  endtask

  task automatic idle_cycles(input int n, input logic en_val);
    En = en_val;
    repeat (n) @(negedge Clk);
    En = 1'b1;
  endtask

  initial begin
    Reset = 1'b1; En = 1'b1; Start = 1'b0; Sign = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0);
    run_op(1'b1, 32'hFFFF_FFFD, 32'd5, 0, 0, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 0, 0, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'd1, 0, 0, 1'b0);
    run_op(1'b0, 32'd7, 32'd3, 0, 0, 1'b0);
    run_op(1'b0, 32'd7, 32'd0, 0, 0, 1'b0);
    run_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 1'b1);
    run_op(1'b1, 32'hDEAD_BEEF, 32'hF00D_1234, 3, 3, 1'b0);
    idle_cycles(3, 1'b0);
    idle_cycles(2, 1'b1);

    // Reset at edge 5 of an operation, then a fresh operation.
    Sign = 1'b0; A = 32'h0BAD_F00D; B = 32'h1234_5678; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    q.delete();
    @(negedge Clk);
    Reset = 1'b0;
    run_op(1'b1, 32'hFFFF_0001, 32'h0000_FFFF, 0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      logic sg;
      int kind;
      kind = $urandom_range(0, 3);
      sg   = 1'($urandom);
      case (kind)
        0:       begin a = $urandom; b = $urandom; end
        1:       begin a = $urandom_range(0, 255); b = $urandom_range(0, 255); end
        2:       begin a = ext[$urandom_range(0, 4)]; b = ext[$urandom_range(0, 4)]; end
        default: begin a = $urandom; b = $urandom_range(0, 4095); end
      endcase
      run_op(sg, a, b, $urandom_range(1, 2), $urandom_range(0, 2), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3), 1'($urandom));
    end

    repeat (3) @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
